// File: rtl/cpu_bus_responder.sv
// Bus responder for the 6502 core: 2 KiB RAM, LED port, 16-bit reload timer with IRQ, vector ROM.
// Reads are combinational from addr_bus and register state; writes commit on the rising CLK edge.
module cpu_bus_responder #(
    parameter int unsigned RAM_AW    = 11,
    parameter logic [15:0] RESET_VEC = 16'h0200,
    parameter logic [15:0] IRQ_VEC   = 16'h0300,
    parameter string       RAM_INIT  = ""
) (
    input  logic        CLK,
    input  logic        R,
    input  logic [15:0] addr_bus,
    input  logic [7:0]  data_out,
    input  logic        data_write,
    output logic [7:0]  data_in,
    output logic [7:0]  leds,
    output logic        irq
);

    localparam int unsigned RAM_DEPTH = 2 ** RAM_AW;

    localparam logic [15:0] A_LEDS    = 16'hD000;
    localparam logic [15:0] A_RLD_LO  = 16'hD001;
    localparam logic [15:0] A_RLD_HI  = 16'hD002;
    localparam logic [15:0] A_CTRL    = 16'hD003;
    localparam logic [15:0] A_CNT_LO  = 16'hD004;
    localparam logic [15:0] A_SNAP    = 16'hD005;
    localparam logic [15:0] A_NMI_LO  = 16'hFFFA;
    localparam logic [15:0] A_NMI_HI  = 16'hFFFB;
    localparam logic [15:0] A_RST_LO  = 16'hFFFC;
    localparam logic [15:0] A_RST_HI  = 16'hFFFD;
    localparam logic [15:0] A_IRQ_LO  = 16'hFFFE;
    localparam logic [15:0] A_IRQ_HI  = 16'hFFFF;

    logic [7:0]  ram_q [RAM_DEPTH];

    logic [7:0]  leds_q, leds_d;
    logic [15:0] rld_q,  rld_d;
    logic [15:0] cnt_q,  cnt_d;
    logic        en_q,   en_d;
    logic        ie_q,   ie_d;
    logic        exp_q,  exp_d;
    logic [7:0]  snap_q, snap_d;

    logic ram_sel;
    logic wr_leds, wr_rld_lo, wr_rld_hi, wr_ctrl;
    logic expire;

    // Full 16-bit decode; nothing above RAM top aliases into it.
    always_comb begin
        ram_sel   = (addr_bus >> RAM_AW) == 16'h0000;
        wr_leds   = data_write && (addr_bus == A_LEDS);
        wr_rld_lo = data_write && (addr_bus == A_RLD_LO);
        wr_rld_hi = data_write && (addr_bus == A_RLD_HI);
        wr_ctrl   = data_write && (addr_bus == A_CTRL);
    end

    always_ff @(posedge CLK) begin
        if (data_write && ram_sel) begin
            ram_q[addr_bus[RAM_AW-1:0]] <= data_out;
        end
    end

    // Register and timer next-state; a RLD_HI write outranks expiry and decrement.
    always_comb begin
        leds_d = leds_q;
        rld_d  = rld_q;
        cnt_d  = cnt_q;
        en_d   = en_q;
        ie_d   = ie_q;
        exp_d  = exp_q;
        snap_d = snap_q;
        expire = 1'b0;

        if (wr_leds)   leds_d       = data_out;
        if (wr_rld_lo) rld_d[7:0]   = data_out;
        if (wr_rld_hi) rld_d[15:8]  = data_out;
        if (wr_ctrl) begin
            en_d = data_out[0];
            ie_d = data_out[1];
        end

        if (wr_rld_hi) begin
            cnt_d = {data_out, rld_q[7:0]};
        end else if (en_q && (cnt_q == 16'h0000)) begin
            cnt_d  = rld_q;
            expire = 1'b1;
        end else if (en_q) begin
            cnt_d = cnt_q - 16'd1;
        end

        // An expiry in the same cycle as a clear keeps the flag set.
        if (expire) begin
            exp_d = 1'b1;
        end else if (wr_ctrl && data_out[7]) begin
            exp_d = 1'b0;
        end

        if (!data_write && (addr_bus == A_CNT_LO)) begin
            snap_d = cnt_q[15:8];
        end
    end

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            leds_q <= 8'h00;
            rld_q  <= 16'hFFFF;
            cnt_q  <= 16'hFFFF;
            en_q   <= 1'b0;
            ie_q   <= 1'b0;
            exp_q  <= 1'b0;
            snap_q <= 8'h00;
        end else begin
            leds_q <= leds_d;
            rld_q  <= rld_d;
            cnt_q  <= cnt_d;
            en_q   <= en_d;
            ie_q   <= ie_d;
            exp_q  <= exp_d;
            snap_q <= snap_d;
        end
    end

    // Zero-latency read mux; same-cycle writes are not forwarded.
    always_comb begin
        data_in = 8'hFF;
        if (ram_sel) begin
            data_in = ram_q[addr_bus[RAM_AW-1:0]];
        end else begin
            case (addr_bus)
                A_LEDS:   data_in = leds_q;
                A_RLD_LO: data_in = rld_q[7:0];
                A_RLD_HI: data_in = rld_q[15:8];
                A_CTRL:   data_in = {exp_q, 5'b00000, ie_q, en_q};
                A_CNT_LO: data_in = cnt_q[7:0];
                A_SNAP:   data_in = snap_q;
                A_NMI_LO: data_in = IRQ_VEC[7:0];
                A_NMI_HI: data_in = IRQ_VEC[15:8];
                A_RST_LO: data_in = RESET_VEC[7:0];
                A_RST_HI: data_in = RESET_VEC[15:8];
                A_IRQ_LO: data_in = IRQ_VEC[7:0];
                A_IRQ_HI: data_in = IRQ_VEC[15:8];
                default:  data_in = 8'hFF;
            endcase
        end
    end

    assign leds = leds_q;
    assign irq  = exp_q & ie_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: vector table for the memory map plus
// hand-written sequences for async reset, timer expiry/clear and snapshot coherence.
module tb_cpu_bus_responder;

    logic        CLK;
    logic        R;
    logic [15:0] addr_bus;
    logic [7:0]  data_out;
    logic        data_write;
    logic [7:0]  data_in;
    logic [7:0]  leds;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    cpu_bus_responder dut (
        .CLK        (CLK),
        .R          (R),
        .addr_bus   (addr_bus),
        .data_out   (data_out),
        .data_write (data_write),
        .data_in    (data_in),
        .leds       (leds),
        .irq        (irq)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        chk_din;
        logic [7:0]  exp_din;
        logic [7:0]  exp_leds;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic wr, input logic [15:0] a, input logic [7:0] d,
                                input logic chk, input logic [7:0] din, input logic [7:0] l);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = d;
        v.chk_din = chk; v.exp_din = din; v.exp_leds = l; v.exp_irq = 1'b0;
        return v;
    endfunction

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 ns later, before the rising edge.
    task automatic drive(input logic wr, input logic [15:0] a, input logic [7:0] d);
        @(negedge CLK);
        data_write = wr;
        addr_bus   = a;
        data_out   = d;
        #2;
    endtask

    initial begin
        R = 1'b1; addr_bus = 16'h0000; data_out = 8'h00; data_write = 1'b0;
        repeat (2) @(negedge CLK);
        R = 1'b0;

        vecs.push_back(mk(0, 16'hFFFC, 8'h00, 1, 8'h00, 8'h00));
        vecs.push_back(mk(0, 16'hFFFD, 8'h00, 1, 8'h02, 8'h00));
        vecs.push_back(mk(0, 16'hFFFA, 8'h00, 1, 8'h00, 8'h00));
        vecs.push_back(mk(0, 16'hFFFB, 8'h00, 1, 8'h03, 8'h00));
        vecs.push_back(mk(0, 16'hFFFE, 8'h00, 1, 8'h00, 8'h00));
        vecs.push_back(mk(0, 16'hFFFF, 8'h00, 1, 8'h03, 8'h00));
        vecs.push_back(mk(0, 16'hD000, 8'h00, 1, 8'h00, 8'h00));
        vecs.push_back(mk(0, 16'hD001, 8'h00, 1, 8'hFF, 8'h00));
        vecs.push_back(mk(0, 16'hD002, 8'h00, 1, 8'hFF, 8'h00));
        vecs.push_back(mk(0, 16'hD003, 8'h00, 1, 8'h00, 8'h00));
        vecs.push_back(mk(0, 16'hD005, 8'h00, 1, 8'h00, 8'h00));
        vecs.push_back(mk(0, 16'hD004, 8'h00, 1, 8'hFF, 8'h00));
        vecs.push_back(mk(0, 16'hD005, 8'h00, 1, 8'hFF, 8'h00));
        vecs.push_back(mk(1, 16'h0000, 8'h5A, 0, 8'h00, 8'h00));
        vecs.push_back(mk(1, 16'h0123, 8'hA5, 0, 8'h00, 8'h00));
        vecs.push_back(mk(0, 16'h0123, 8'h00, 1, 8'hA5, 8'h00));
        vecs.push_back(mk(1, 16'h0800, 8'h77, 1, 8'hFF, 8'h00));
        vecs.push_back(mk(0, 16'h0800, 8'h00, 1, 8'hFF, 8'h00));
        vecs.push_back(mk(0, 16'h0000, 8'h00, 1, 8'h5A, 8'h00));
        vecs.push_back(mk(1, 16'h0123, 8'h33, 1, 8'hA5, 8'h00));
        vecs.push_back(mk(0, 16'h0123, 8'h00, 1, 8'h33, 8'h00));
        vecs.push_back(mk(1, 16'hD000, 8'h3C, 1, 8'h00, 8'h00));
        vecs.push_back(mk(0, 16'hD000, 8'h00, 1, 8'h3C, 8'h3C));
        vecs.push_back(mk(1, 16'hFFFC, 8'h11, 1, 8'h00, 8'h3C));
        vecs.push_back(mk(0, 16'hFFFC, 8'h00, 1, 8'h00, 8'h3C));
        vecs.push_back(mk(1, 16'hE000, 8'h22, 1, 8'hFF, 8'h3C));
        vecs.push_back(mk(0, 16'hE000, 8'h00, 1, 8'hFF, 8'h3C));
        vecs.push_back(mk(0, 16'h1234, 8'h00, 1, 8'hFF, 8'h3C));
        vecs.push_back(mk(0, 16'hD006, 8'h00, 1, 8'hFF, 8'h3C));
        vecs.push_back(mk(0, 16'h0123, 8'h00, 1, 8'h33, 8'h3C));
        vecs.push_back(mk(0, 16'hD003, 8'h00, 1, 8'h00, 8'h3C));
        vecs.push_back(mk(0, 16'hD000, 8'h00, 1, 8'h3C, 8'h3C));

        foreach (vecs[i]) begin
            drive(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].chk_din) chk8($sformatf("v%0d_din", i), data_in, vecs[i].exp_din);
            chk8($sformatf("v%0d_leds", i), leds, vecs[i].exp_leds);
            chk8($sformatf("v%0d_irq", i), {7'd0, irq}, {7'd0, vecs[i].exp_irq});
        end

        // Asynchronous reset in the low phase, with no clock edge in between.
        drive(0, 16'hD000, 8'h00);
        chk8("pre_rst_leds", leds, 8'h3C);
        R = 1'b1;
        #1;
        chk8("async_rst_leds", leds, 8'h00);
        chk8("async_rst_din", data_in, 8'h00);
        R = 1'b0;
        drive(0, 16'hD004, 8'h00);
        chk8("rst_cnt_lo", data_in, 8'hFF);

        // Timer with RLD=3: expiry after 4 edges, then every 4 edges.
        drive(1, 16'hD001, 8'h03);
        drive(1, 16'hD002, 8'h00);
        drive(1, 16'hD003, 8'h03);
        for (int e = 0; e < 10; e++) begin
            drive(0, 16'hD004, 8'h00);
            chk8($sformatf("tmr_cnt_e%0d", e), data_in, 8'(3 - (e % 4)));
            chk8($sformatf("tmr_irq_e%0d", e), {7'd0, irq}, {7'd0, (e >= 4) ? 1'b1 : 1'b0});
        end
        drive(1, 16'hD003, 8'h83);
        chk8("clr_pre", data_in, 8'h83);
        drive(1, 16'hD003, 8'h83);
        chk8("clr_done", data_in, 8'h03);
        chk8("clr_irq", {7'd0, irq}, 8'h00);
        drive(0, 16'hD003, 8'h00);
        chk8("set_wins", data_in, 8'h83);
        chk8("set_wins_irq", {7'd0, irq}, 8'h01);
        drive(1, 16'hD003, 8'h01);
        chk8("ie_off_pre", data_in, 8'h83);
        drive(0, 16'hD003, 8'h00);
        chk8("ie_off", data_in, 8'h81);
        chk8("ie_off_irq", {7'd0, irq}, 8'h00);
        drive(1, 16'hD003, 8'h80);
        chk8("dis_pre", data_in, 8'h81);
        drive(0, 16'hD003, 8'h00);
        chk8("dis_set_wins", data_in, 8'h80);
        drive(1, 16'hD003, 8'h80);
        drive(0, 16'hD003, 8'h00);
        chk8("dis_clear", data_in, 8'h00);
        drive(0, 16'hD004, 8'h00);
        chk8("dis_hold", data_in, 8'h03);

        // Snapshot coherence across a low-byte borrow with RLD=0x0100.
        drive(1, 16'hD001, 8'h00);
        drive(1, 16'hD002, 8'h01);
        drive(1, 16'hD003, 8'h01);
        drive(0, 16'hD004, 8'h00);
        chk8("snap_lo", data_in, 8'h00);
        drive(0, 16'hD000, 8'h00);
        drive(0, 16'hD005, 8'h00);
        chk8("snap_hi", data_in, 8'h01);
        drive(0, 16'hD004, 8'h00);
        chk8("snap_lo2", data_in, 8'hFD);
        drive(0, 16'hD005, 8'h00);
        chk8("snap_hi2", data_in, 8'h00);

        // RLD=0 with EN: expiry every cycle defeats a clear.
        drive(1, 16'hD001, 8'h00);
        drive(1, 16'hD002, 8'h00);
        drive(1, 16'hD003, 8'h83);
        chk8("rld0_pre", data_in, 8'h01);
        drive(1, 16'hD003, 8'h83);
        chk8("rld0_set", data_in, 8'h83);
        chk8("rld0_irq", {7'd0, irq}, 8'h01);
        drive(0, 16'hD003, 8'h00);
        chk8("rld0_stay", data_in, 8'h83);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
